bnn_vote_filter: RTL and testbench
==================================

BNN_VOTE_FILTER -- requirements
Module: bnn_vote_filter

Interface
REQ-001 Parameter WINDOW, default 8; number of most recent classifier results held; legal values 4, 8 or 16.
REQ-002 Parameter HYST, default 1; vote-margin hysteresis around WINDOW/2; legal range 0 to WINDOW/2-1.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  block enable; low = inputs ignored, all state and outputs held.
REQ-006 flush  input  1  synchronous clear of window, counters, decision and overrun.
REQ-007 res_valid  input  1  one-cycle strobe from upstream BNN classifier DONE state.
REQ-008 res_class  input  1  classifier result, 0 = class A, 1 = class B; sampled only with res_valid.
REQ-009 out_ready  input  1  downstream accepts the current output record.
REQ-010 out_valid  output  1  output record available.
REQ-011 out_class  output  1  filtered (hysteretic majority) class.
REQ-012 out_ones  output  5  count of class-1 results currently in the window.
REQ-013 out_full  output  1  window holds WINDOW results.
REQ-014 overrun  output  1  sticky; an unaccepted record was overwritten.

Function
REQ-015 Accepted result = res_valid & ena & !flush in a cycle.
REQ-016 Window is a WINDOW-bit shift register; each accepted result shifts in at bit 0, bit WINDOW-1 is evicted.
REQ-017 Fill counter increments per accepted result, saturates at WINDOW; out_full = (fill == WINDOW).
REQ-018 ones counter updated incrementally: +res_class, -evicted bit only when fill == WINDOW before the shift; never below 0 nor above WINDOW.
REQ-019 State machine: FILL (fill < WINDOW) -> TRACK on the accept that makes fill == WINDOW; TRACK -> FILL only on flush or reset.
REQ-020 In FILL, out_class holds its value; no decision is made.
REQ-021 In TRACK, after each accept: ones >= WINDOW/2+HYST -> out_class = 1; ones <= WINDOW/2-HYST -> out_class = 0; otherwise out_class unchanged.
REQ-022 The decision uses the post-update ones value, i.e. includes the result just accepted.
REQ-023 Latency: result accepted in cycle N -> out_ones, out_full, out_class, out_valid updated and visible in cycle N+1.
REQ-024 Every accepted result (FILL or TRACK) produces one output record: out_valid set in the next cycle.
REQ-025 out_valid clears the cycle after out_valid & out_ready, unless a new accept occurs in the same cycle (then it stays high with the new record).
REQ-026 Accept while out_valid & !out_ready: record overwritten, overrun set to 1 and held.
REQ-027 Accept while out_valid & out_ready in the same cycle: no overrun.
REQ-028 flush: window, fill, ones, out_valid, out_class and overrun -> 0, state -> FILL next cycle; flush overrides a simultaneous res_valid.
REQ-029 ena low: accepts and flush ignored, out_ready handshake frozen, all registers hold.

Reset
REQ-030 rst_n low asynchronously forces window = 0, fill = 0, ones = 0, state = FILL, out_valid = 0, out_class = 0, out_ones = 0, out_full = 0, overrun = 0.
REQ-031 Reset asserted mid-operation discards any pending record with no partial update; first accept after release is treated as the first result.

Structure
REQ-032 Shared package bnn_pkg holds the WINDOW/HYST defaults, the class encoding constants (CLASS_A = 0, CLASS_B = 1) and the FILL/TRACK state enumeration.
REQ-033 One sub-module, bnn_vote_window, holds the shift register, the fill and ones counters and the eviction logic; the top level holds the FSM, decision and handshake logic.

Verification
REQ-034 Reset, then 8 accepts of class 1 with out_ready = 1 -> out_full = 0 after the first 7, out_ones = 8, out_full = 1 and out_class = 1 after the 8th.
REQ-035 Full window of 8×1, then class 0 results one by one -> out_class stays 1 while ones >= 4 (through 5, 4), becomes 0 only when ones = 3.
REQ-036 out_ready = 0, two accepts 3 cycles apart -> out_valid = 1 after the first accept, overrun = 1 after the second; overrun clears only after flush.
REQ-037 res_valid and flush high together with window 8×1 -> next cycle out_ones = 0, out_full = 0, out_valid = 0, state FILL.
REQ-038 ena = 0 with res_valid pulses -> no change in out_ones or out_valid; ena = 1 resumes from the held counts.
REQ-039 rst_n pulsed low asynchronously while out_valid = 1 and ones = 6 -> all outputs 0 immediately; the first accept afterwards gives out_ones = res_class.

Source files
------------

// File: rtl/bnn_pkg.sv
// ---------------------------------------------------------------------------
// bnn_pkg
// Shared definitions for the BNN vote filter slice.
// Contents:
//   WINDOW_DEFAULT / HYST_DEFAULT : default window depth and vote hysteresis
//   CLASS_A / CLASS_B             : classifier result encoding
//   STATE_FILL / STATE_TRACK      : vote filter state encoding
//   COUNT_W                       : width of the fill and ones counters
//   countConst()                  : sizes an integer constant to COUNT_W bits
// ---------------------------------------------------------------------------
package bnn_pkg;

  localparam int WINDOW_DEFAULT = 8;
  localparam int HYST_DEFAULT   = 1;

  localparam logic CLASS_A = 1'b0;
  localparam logic CLASS_B = 1'b1;

  localparam logic [0:0] STATE_FILL  = 1'b0;
  localparam logic [0:0] STATE_TRACK = 1'b1;

  // Wide enough to hold the value 16 for the deepest legal window.
  localparam int COUNT_W = 5;

  function automatic logic [COUNT_W-1:0] countConst(input int value);
    return COUNT_W'(value);
  endfunction

endpackage

// File: rtl/bnn_vote_window.sv
// ---------------------------------------------------------------------------
// bnn_vote_window
// Holds the most recent WINDOW classifier results, a saturating fill count
// and an incrementally maintained count of class-B results in the window.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   accept_i       : shift class_i into the window this cycle
//   flush_i        : synchronous clear (wins over accept_i)
//   class_i        : result bit to shift in
//   ones_o         : registered count of ones in the window
//   full_o         : registered window-full flag
//   ones_next_o    : ones count after this cycle's update (for decisions)
//   full_next_o    : window-full flag after this cycle's update
// ---------------------------------------------------------------------------
module bnn_vote_window
  import bnn_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               accept_i,
  input  logic               flush_i,
  input  logic               class_i,
  output logic [COUNT_W-1:0] ones_o,
  output logic               full_o,
  output logic [COUNT_W-1:0] ones_next_o,
  output logic               full_next_o
);

  localparam logic [COUNT_W-1:0] FULL_COUNT = countConst(WINDOW);

  logic [WINDOW-1:0]  window_q, window_d;
  logic [COUNT_W-1:0] fill_q, fill_d;
  logic [COUNT_W-1:0] ones_q, ones_d;
  logic               evictBit;

  // The oldest bit only leaves the count once the window is really full;
  // before that the top bit is still reset padding, not a result.
  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    ones_d   = ones_q;
    evictBit = (fill_q == FULL_COUNT) ? window_q[WINDOW-1] : 1'b0;
    if (flush_i) begin
      window_d = '0;
      fill_d   = '0;
      ones_d   = '0;
    end else if (accept_i) begin
      window_d = {window_q[WINDOW-2:0], class_i};
      fill_d   = (fill_q == FULL_COUNT) ? fill_q : fill_q + 1'b1;
      ones_d   = ones_q + {{(COUNT_W-1){1'b0}}, class_i}
                        - {{(COUNT_W-1){1'b0}}, evictBit};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_q <= '0;
      fill_q   <= '0;
      ones_q   <= '0;
    end else begin
      window_q <= window_d;
      fill_q   <= fill_d;
      ones_q   <= ones_d;
    end
  end

  assign ones_o      = ones_q;
  assign full_o      = (fill_q == FULL_COUNT);
  assign ones_next_o = ones_d;
  assign full_next_o = (fill_d == FULL_COUNT);

endmodule

// File: rtl/bnn_vote_filter.sv
// ---------------------------------------------------------------------------
// bnn_vote_filter
// Smooths a stream of single-bit BNN classifier results with a hysteretic
// majority vote over the last WINDOW results and presents each update as an
// output record with a valid/ready handshake.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   ena         : block enable; when low everything holds
//   flush       : synchronous clear of window, counters, decision, overrun
//   res_valid   : result strobe from the classifier
//   res_class   : classifier result (CLASS_A / CLASS_B)
//   out_ready   : downstream accepts the current record
//   out_valid   : output record available
//   out_class   : filtered class decision
//   out_ones    : class-B results currently in the window
//   out_full    : window holds WINDOW results
//   overrun     : sticky; an unaccepted record was overwritten
// ---------------------------------------------------------------------------
module bnn_vote_filter
  import bnn_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEFAULT,
  parameter int HYST   = HYST_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               flush,
  input  logic               res_valid,
  input  logic               res_class,
  input  logic               out_ready,
  output logic               out_valid,
  output logic               out_class,
  output logic [COUNT_W-1:0] out_ones,
  output logic               out_full,
  output logic               overrun
);

  localparam logic [COUNT_W-1:0] SET_TH   = countConst(WINDOW / 2 + HYST);
  localparam logic [COUNT_W-1:0] CLEAR_TH = countConst(WINDOW / 2 - HYST);

  logic               acceptRes;
  logic               flushEn;
  logic [COUNT_W-1:0] onesNext;
  logic               fullNext;

  logic [0:0] state_q, state_d;
  logic       outClass_q, outClass_d;
  logic       outValid_q, outValid_d;
  logic       overrun_q, overrun_d;

  // Flush is ignored while disabled and beats a simultaneous result.
  assign flushEn   = flush & ena;
  assign acceptRes = res_valid & ena & ~flush;

  bnn_vote_window #(
    .WINDOW (WINDOW)
  ) u_window (
    .clk         (clk),
    .rst_n       (rst_n),
    .accept_i    (acceptRes),
    .flush_i     (flushEn),
    .class_i     (res_class),
    .ones_o      (out_ones),
    .full_o      (out_full),
    .ones_next_o (onesNext),
    .full_next_o (fullNext)
  );

  // The accept that completes the window already votes, so a decision is
  // made whenever the post-update window is full. Between the two thresholds
  // the previous decision is kept.
  always_comb begin
    state_d    = state_q;
    outClass_d = outClass_q;
    outValid_d = outValid_q;
    overrun_d  = overrun_q;
    if (flushEn) begin
      state_d    = STATE_FILL;
      outClass_d = CLASS_A;
      outValid_d = 1'b0;
      overrun_d  = 1'b0;
    end else if (acceptRes) begin
      outValid_d = 1'b1;
      if (outValid_q && !out_ready) begin
        overrun_d = 1'b1;
      end
      if ((state_q == STATE_TRACK) || fullNext) begin
        state_d = STATE_TRACK;
        if (onesNext >= SET_TH) begin
          outClass_d = CLASS_B;
        end else if (onesNext <= CLEAR_TH) begin
          outClass_d = CLASS_A;
        end
      end
    end else if (ena && outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= STATE_FILL;
      outClass_q <= CLASS_A;
      outValid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      outClass_q <= outClass_d;
      outValid_q <= outValid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_class = outClass_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_bnn_vote_filter.sv
// ---------------------------------------------------------------------------
// tb_bnn_vote_filter
// Directed self-checking bench for bnn_vote_filter (WINDOW = 8, HYST = 1,
// so the decision sets at ones >= 5 and clears at ones <= 3).
// ---------------------------------------------------------------------------
module tb_bnn_vote_filter;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       flush;
  logic       res_valid;
  logic       res_class;
  logic       out_ready;
  logic       out_valid;
  logic       out_class;
  logic [4:0] out_ones;
  logic       out_full;
  logic       overrun;

  int testsRun;
  int testsFailed;

  bnn_vote_filter #(
    .WINDOW (8),
    .HYST   (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .flush     (flush),
    .res_valid (res_valid),
    .res_class (res_class),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_class (out_class),
    .out_ones  (out_ones),
    .out_full  (out_full),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value with its expected value and tallies it.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, lets a rising edge pass and returns 1 ns
  // after it with the strobes (res_valid, flush) dropped again.
  task automatic applyStimulus(input logic valid, input logic cls, input logic ready,
                               input logic doFlush, input logic enable);
    res_valid = valid;
    res_class = cls;
    out_ready = ready;
    flush     = doFlush;
    ena       = enable;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, int'(out_valid), 0);
    checkOutput({tag, "_class"}, int'(out_class), 0);
    checkOutput({tag, "_ones"}, int'(out_ones), 0);
    checkOutput({tag, "_full"}, int'(out_full), 0);
    checkOutput({tag, "_overrun"}, int'(overrun), 0);
  endtask

  // Hand-computed tables for the eviction / hysteresis sequences.
  int zeroOnes[5]  = '{7, 6, 5, 4, 3};
  int zeroClass[5] = '{1, 1, 1, 1, 0};
  int oneOnes[5]   = '{3, 3, 3, 4, 5};
  int oneClass[5]  = '{0, 0, 0, 0, 1};

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n     = 1'b0;
    ena       = 1'b1;
    flush     = 1'b0;
    res_valid = 1'b0;
    res_class = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #2;
    checkAllZero("reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Eight class-B results fill the window; the 8th also votes.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput($sformatf("fill%0d_ones", i), int'(out_ones), i);
      checkOutput($sformatf("fill%0d_full", i), int'(out_full), (i == 8) ? 1 : 0);
      checkOutput($sformatf("fill%0d_valid", i), int'(out_valid), 1);
    end
    checkOutput("fill_class", int'(out_class), 1);
    checkOutput("fill_overrun", int'(overrun), 0);

    // Record taken with no new result -> out_valid drops.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("drain_valid", int'(out_valid), 0);

    // Class-A results one by one: holds 1 through 5 and 4, clears at 3.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput($sformatf("down%0d_ones", i), int'(out_ones), zeroOnes[i]);
      checkOutput($sformatf("down%0d_class", i), int'(out_class), zeroClass[i]);
    end

    // Class-B results again: first three evict ones, then 4 (hold), 5 (set).
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput($sformatf("up%0d_ones", i), int'(out_ones), oneOnes[i]);
      checkOutput($sformatf("up%0d_class", i), int'(out_class), oneClass[i]);
    end
    checkOutput("up_overrun", int'(overrun), 0);

    // Overrun: downstream stalled, two accepts three cycles apart.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("ovr_idle_valid", int'(out_valid), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ovr_first_valid", int'(out_valid), 1);
    checkOutput("ovr_first_overrun", int'(overrun), 0);
    checkOutput("ovr_first_ones", int'(out_ones), 5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ovr_hold_valid", int'(out_valid), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ovr_second_overrun", int'(overrun), 1);
    checkOutput("ovr_second_class", int'(out_class), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("ovr_taken_valid", int'(out_valid), 0);
    checkOutput("ovr_sticky", int'(overrun), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkAllZero("ovr_flush");

    // Flush together with a result, window full of ones.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    end
    checkOutput("pre_flush_ones", int'(out_ones), 8);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkAllZero("flush_res");
    // Back in FILL: a lone class-B result neither fills nor votes.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("post_flush_ones", int'(out_ones), 1);
    checkOutput("post_flush_full", int'(out_full), 0);
    checkOutput("post_flush_class", int'(out_class), 0);

    // Disabled: results, handshake and flush are all ignored.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("dis%0d_ones", i), int'(out_ones), 1);
      checkOutput($sformatf("dis%0d_valid", i), int'(out_valid), 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("dis_flush_ones", int'(out_ones), 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("resume_ones", int'(out_ones), 2);

    // Build ones = 6 with a pending record, then reset between edges.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("pre_rst_ones", int'(out_ones), 6);
    checkOutput("pre_rst_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("after_rst_ones", int'(out_ones), 1);
    checkOutput("after_rst_full", int'(out_full), 0);
    checkOutput("after_rst_valid", int'(out_valid), 1);
    checkOutput("after_rst_overrun", int'(overrun), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
